// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back formatter driving the GPR write port.
// Latency: one cycle from in_* capture to the register-file write. Stall holds the stage and suppresses repeat writes.
module wb_stage #(
    parameter logic [31:0] RESET_PC    = 32'h00003000,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic        in_regwrite,
    input  logic [4:0]  in_wreg,
    input  logic [1:0]  in_wbsel,
    input  logic [2:0]  in_ldtype,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_memword,
    output logic [31:0] PC,
    output logic [4:0]  WReg,
    output logic [31:0] Data,
    output logic        RegWrite,
    output logic        fwd_valid,
    output logic [31:0] commit_count
);

    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic        r_valid;
    logic        r_written;
    logic [31:0] r_pc;
    logic        r_regwrite;
    logic [4:0]  r_wreg;
    logic [1:0]  r_wbsel;
    logic [2:0]  r_ldtype;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_alu;
    logic [31:0] r_memword;
    logic [31:0] r_commit_count;

    logic        w_fwd;
    logic        w_regwrite;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_data;

    // A held instruction stays the newest producer, but may only write once.
    assign w_fwd      = r_valid & r_regwrite & (r_wreg != 5'd0);
    assign w_regwrite = w_fwd & ~r_written;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_written  <= 1'b0;
            r_pc       <= RESET_PC;
            r_regwrite <= 1'b0;
            r_wreg     <= 5'd0;
            r_wbsel    <= 2'd0;
            r_ldtype   <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_alu      <= 32'd0;
            r_memword  <= 32'd0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_written  <= 1'b0;
            r_pc       <= RESET_PC;
            r_regwrite <= 1'b0;
            r_wreg     <= 5'd0;
            r_wbsel    <= 2'd0;
            r_ldtype   <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_alu      <= 32'd0;
            r_memword  <= 32'd0;
        end else if (stall) begin
            r_written  <= r_written | w_regwrite;
        end else begin
            r_valid    <= in_valid;
            r_written  <= 1'b0;
            r_pc       <= in_pc;
            r_regwrite <= in_regwrite;
            r_wreg     <= in_wreg;
            r_wbsel    <= in_wbsel;
            r_ldtype   <= in_ldtype;
            r_addr_lo  <= in_addr_lo;
            r_alu      <= in_alu;
            r_memword  <= in_memword;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commit_count <= 32'd0;
        end else if (!flush && w_regwrite) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    always_comb begin
        w_byte = r_memword[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = r_memword[15:8];
            2'd2:    w_byte = r_memword[23:16];
            2'd3:    w_byte = r_memword[31:24];
            default: w_byte = r_memword[7:0];
        endcase
        w_half = r_addr_lo[1] ? r_memword[31:16] : r_memword[15:0];

        // Unlisted load types fall back to a full word.
        case (r_ldtype)
            LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load = {24'd0, w_byte};
            LD_LH:   w_load = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load = {16'd0, w_half};
            default: w_load = r_memword;
        endcase

        case (r_wbsel)
            WB_MEM:  w_data = w_load;
            WB_LINK: w_data = r_pc + LINK_OFFSET;
            default: w_data = r_alu;
        endcase
    end

    assign PC           = r_pc;
    assign WReg         = r_wreg;
    assign Data         = w_data;
    assign RegWrite     = w_regwrite;
    assign fwd_valid    = w_fwd;
    assign commit_count = r_commit_count;

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: table of single-cycle cases plus stall, flush and reset sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_regwrite;
    logic [31:0] in_pc, in_alu, in_memword;
    logic [4:0]  in_wreg;
    logic [1:0]  in_wbsel, in_addr_lo;
    logic [2:0]  in_ldtype;
    logic [31:0] PC, Data, commit_count;
    logic [4:0]  WReg;
    logic        RegWrite, fwd_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_regwrite(in_regwrite),
        .in_wreg(in_wreg), .in_wbsel(in_wbsel), .in_ldtype(in_ldtype),
        .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_memword(in_memword),
        .PC(PC), .WReg(WReg), .Data(Data), .RegWrite(RegWrite),
        .fwd_valid(fwd_valid), .commit_count(commit_count)
    );

    typedef struct {
        logic        vld;
        logic        rw;
        logic [4:0]  wreg;
        logic [1:0]  wbsel;
        logic [2:0]  ld;
        logic [1:0]  lo;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        e_rw;
        logic        e_fwd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid    = v.vld;
        in_regwrite = v.rw;
        in_wreg     = v.wreg;
        in_wbsel    = v.wbsel;
        in_ldtype   = v.ld;
        in_addr_lo  = v.lo;
        in_pc       = v.pc;
        in_alu      = v.alu;
        in_memword  = v.mem;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_regwrite = 1'b0; in_wreg = 5'd0; in_wbsel = 2'd0;
        in_ldtype = 3'd0; in_addr_lo = 2'd0; in_pc = 32'd0; in_alu = 32'd0;
        in_memword = 32'd0;
    endtask

    logic [31:0] exp_cnt;
    logic        prev_rw;
    vec_t        w;

    initial begin
        //        vld  rw  wreg   wbsel ld    lo    pc            alu           mem           e_rw e_fwd e_data
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'd0, 3'd0, 2'd0, 32'h00003000, 32'h12345678, 32'h0,        1'b1, 1'b1, 32'h12345678};
        vecs[1]  = '{1'b1, 1'b1, 5'd9,  2'd1, 3'd1, 2'd3, 32'h00003004, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b1, 5'd9,  2'd1, 3'd2, 2'd3, 32'h00003008, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'h00000080};
        vecs[3]  = '{1'b1, 1'b1, 5'd10, 2'd1, 3'd3, 2'd2, 32'h0000300C, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'hFFFF80FF};
        vecs[4]  = '{1'b1, 1'b1, 5'd11, 2'd1, 3'd4, 2'd0, 32'h00003010, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'h00007F01};
        vecs[5]  = '{1'b1, 1'b1, 5'd12, 2'd1, 3'd0, 2'd1, 32'h00003014, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'h80FF7F01};
        vecs[6]  = '{1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h00003010, 32'hDEADBEEF, 32'h0,        1'b1, 1'b1, 32'h00003018};
        vecs[7]  = '{1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00000004};
        vecs[8]  = '{1'b1, 1'b1, 5'd0,  2'd0, 3'd0, 2'd0, 32'h00003020, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b1, 5'd3,  2'd3, 3'd0, 2'd0, 32'h00003024, 32'h0BADC0DE, 32'h0,        1'b1, 1'b1, 32'h0BADC0DE};
        vecs[10] = '{1'b0, 1'b1, 5'd7,  2'd0, 3'd0, 2'd0, 32'h00003028, 32'h11111111, 32'h0,        1'b0, 1'b0, 32'h11111111};
        vecs[11] = '{1'b1, 1'b1, 5'd13, 2'd1, 3'd1, 2'd1, 32'h0000302C, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'h0000007F};
        vecs[12] = '{1'b1, 1'b1, 5'd14, 2'd1, 3'd1, 2'd2, 32'h00003030, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[13] = '{1'b1, 1'b1, 5'd15, 2'd1, 3'd3, 2'd3, 32'h00003034, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'hFFFF80FF};
        vecs[14] = '{1'b1, 1'b1, 5'd16, 2'd1, 3'd4, 2'd2, 32'h00003038, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 32'h000080FF};
        vecs[15] = '{1'b1, 1'b0, 5'd17, 2'd1, 3'd7, 2'd1, 32'h0000303C, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 32'h80FF7F01};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", PC, 32'h00003000);
        chk("reset_wreg", {27'd0, WReg}, 32'd0);
        chk("reset_data", Data, 32'd0);
        chk("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("reset_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("reset_count", commit_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        exp_cnt = 32'd0;
        prev_rw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            if (prev_rw) exp_cnt = exp_cnt + 32'd1;
            #1;
            chk($sformatf("v%0d_data", i), Data, vecs[i].e_data);
            chk($sformatf("v%0d_rw", i), {31'd0, RegWrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_fwd", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_fwd});
            chk($sformatf("v%0d_wreg", i), {27'd0, WReg}, {27'd0, vecs[i].wreg});
            chk($sformatf("v%0d_pc", i), PC, vecs[i].pc);
            chk($sformatf("v%0d_count", i), commit_count, exp_cnt);
            prev_rw = vecs[i].e_rw;
        end

        // Drain: vector 15 did not write, so count stays.
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("drain_count", commit_count, exp_cnt);

        // Stall dedup: write to $8 held for three edges.
        @(negedge clk);
        w = '{1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h00003100, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b1, 32'hA5A5A5A5};
        drive(w);
        @(posedge clk);
        #1;
        chk("stall_c0_rw", {31'd0, RegWrite}, 32'd1);
        chk("stall_c0_fwd", {31'd0, fwd_valid}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            stall = 1'b1;
            in_wreg = 5'd3; in_alu = 32'h0; in_pc = 32'h0;
            @(posedge clk);
            #1;
            chk($sformatf("stall_c%0d_rw", c), {31'd0, RegWrite}, 32'd0);
            chk($sformatf("stall_c%0d_fwd", c), {31'd0, fwd_valid}, 32'd1);
            chk($sformatf("stall_c%0d_wreg", c), {27'd0, WReg}, 32'd8);
            chk($sformatf("stall_c%0d_data", c), Data, 32'hA5A5A5A5);
            chk($sformatf("stall_c%0d_count", c), commit_count, exp_cnt + 32'd1);
        end
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        stall = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("stall_release_count", commit_count, exp_cnt);

        // Flush together with stall loads a bubble.
        @(negedge clk);
        w = '{1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 2'd0, 32'h00003200, 32'h55AA55AA, 32'h0, 1'b1, 1'b1, 32'h55AA55AA};
        drive(w);
        @(posedge clk);
        #1;
        chk("flush_pre_rw", {31'd0, RegWrite}, 32'd1);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_pc", PC, 32'h00003000);
        chk("flush_rw", {31'd0, RegWrite}, 32'd0);
        chk("flush_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("flush_wreg", {27'd0, WReg}, 32'd0);
        chk("flush_count", commit_count, exp_cnt);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;

        // Async reset mid-cycle while a write is held.
        w = '{1'b1, 1'b1, 5'd20, 2'd0, 3'd0, 2'd0, 32'h00003300, 32'h77777777, 32'h0, 1'b1, 1'b1, 32'h77777777};
        drive(w);
        @(posedge clk);
        #1;
        chk("prereset_count", commit_count, exp_cnt);
        chk("prereset_rw", {31'd0, RegWrite}, 32'd1);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_pc", PC, 32'h00003000);
        chk("areset_rw", {31'd0, RegWrite}, 32'd0);
        chk("areset_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("areset_count", commit_count, 32'd0);
        chk("areset_data", Data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("post_reset_rw", {31'd0, RegWrite}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
